// File: rtl/alu_fu_pkg.sv
// Shared types for the integer ALU functional unit: op encoding, issue uop and CDB packet.
// Used by alu_core and alu_fu; the optional ALU_FU_PIPE2_EN build uses the same types.
package alu_fu_pkg;

  localparam int XLEN       = 32;
  localparam int DATA_WIDTH = 6;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_W      = $clog2(ROB_DEPTH);
  localparam int RD_W       = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t               op;
    logic [XLEN-1:0]       a;
    logic [XLEN-1:0]       b;
    logic [DATA_WIDTH-1:0] pd;
    logic [RD_W-1:0]       rd;
    logic [ROB_W-1:0]      rob_idx;
    logic                  valid;
  } alu_fu_uop_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pd;
    logic [RD_W-1:0]       rd;
    logic [ROB_W-1:0]      rob_idx;
    logic [XLEN-1:0]       value;
    logic                  valid;
  } cdb_pkt_t;

  // x0 writes still complete in the ROB, but must never carry a nonzero value.
  function automatic logic [XLEN-1:0] mask_rd0(input logic [RD_W-1:0] rd,
                                               input logic [XLEN-1:0] value);
    return (rd == '0) ? '0 : value;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV32I integer datapath: (op, a, b) -> result, all arithmetic mod 2^XLEN.
module alu_core
  import alu_fu_pkg::*;
(
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  assign shamt       = b[4:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fu.sv
// ALU functional unit: takes one issued op per cycle, holds the result in OUT until the CDB grants it.
// Define ALU_FU_PIPE2_EN to add a registered operand stage E1 (latency 2 instead of 1).
module alu_fu
  import alu_fu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_commit,
  input  logic                  issue_valid,
  input  alu_op_t               issue_op,
  input  logic                  issue_a_pc,
  input  logic                  issue_b_imm,
  input  logic [XLEN-1:0]       issue_pc,
  input  logic [XLEN-1:0]       issue_imm,
  input  logic [XLEN-1:0]       rs1_v,
  input  logic [XLEN-1:0]       rs2_v,
  input  logic [DATA_WIDTH-1:0] issue_pd,
  input  logic [RD_W-1:0]       issue_rd,
  input  logic [ROB_W-1:0]      issue_rob_idx,
  output logic                  funit_ready_alu,
  output logic                  cdb_req,
  input  logic                  cdb_grant,
  output logic [DATA_WIDTH-1:0] cdb_pd,
  output logic [RD_W-1:0]       cdb_rd,
  output logic [ROB_W-1:0]      cdb_rob_idx,
  output logic [XLEN-1:0]       cdb_value
);

  logic        issue_fire;
  alu_fu_uop_t issue_uop;
  alu_fu_uop_t src_uop;
  logic        out_load;
  logic [XLEN-1:0] core_result;
  cdb_pkt_t    out_q;

  assign issue_fire = issue_valid && funit_ready_alu && !jump_commit;

  always_comb begin
    issue_uop         = '0;
    issue_uop.op      = issue_op;
    issue_uop.a       = issue_a_pc  ? issue_pc  : rs1_v;
    issue_uop.b       = issue_b_imm ? issue_imm : rs2_v;
    issue_uop.pd      = issue_pd;
    issue_uop.rd      = issue_rd;
    issue_uop.rob_idx = issue_rob_idx;
    issue_uop.valid   = issue_fire;
  end

`ifdef ALU_FU_PIPE2_EN
  alu_fu_uop_t e1_q;
  logic        out_free;
  logic        e1_adv;

  // E1 moves into OUT whenever OUT is empty or draining this cycle, so throughput stays 1/cycle.
  assign out_free        = !out_q.valid || cdb_grant;
  assign e1_adv          = e1_q.valid && out_free;
  assign funit_ready_alu = !e1_q.valid || e1_adv;
  assign src_uop         = e1_q;
  assign out_load        = e1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q <= '0;
    end else if (jump_commit) begin
      e1_q.valid <= 1'b0;
    end else if (issue_fire) begin
      e1_q <= issue_uop;
    end else if (e1_adv) begin
      e1_q.valid <= 1'b0;
    end
  end
`else
  // Combinational from cdb_grant: a granted OUT can be refilled in the same cycle.
  assign funit_ready_alu = !out_q.valid || cdb_grant;
  assign src_uop         = issue_uop;
  assign out_load        = issue_uop.valid;
`endif

  alu_core u_alu_core (
    .op     (src_uop.op),
    .a      (src_uop.a),
    .b      (src_uop.b),
    .result (core_result)
  );

  // Fields stay frozen while waiting for grant; only valid drops on grant or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (jump_commit) begin
      out_q.valid <= 1'b0;
    end else if (out_load) begin
      out_q.pd      <= src_uop.pd;
      out_q.rd      <= src_uop.rd;
      out_q.rob_idx <= src_uop.rob_idx;
      out_q.value   <= mask_rd0(src_uop.rd, core_result);
      out_q.valid   <= 1'b1;
    end else if (cdb_grant) begin
      out_q.valid <= 1'b0;
    end
  end

  assign cdb_req     = out_q.valid;
  assign cdb_pd      = out_q.pd;
  assign cdb_rd      = out_q.rd;
  assign cdb_rob_idx = out_q.rob_idx;
  assign cdb_value   = out_q.value;

`ifndef SYNTHESIS
  issue_while_busy : assert property (
    @(posedge clk) disable iff (!rst_n)
    (issue_valid && !jump_commit) |-> funit_ready_alu
  ) else $error("alu_fu: issue_valid asserted while funit_ready_alu is low");
`endif

endmodule
